// File: rtl/xbus_bridge.sv
// xbus_bridge
//   Bridges a single-beat Wishbone-style slave port onto an external
//   asynchronous bus with chip select, separate read/write strobes and an
//   optional device ready handshake.
//
//   Parameters
//     SETUP_CYC   : address/CS setup cycles before the strobe (1..3)
//     HOLD_CYC    : cycles CS stays low after the strobe is released (1..3)
//     TIMEOUT_CYC : longest strobe (in cycles) while waiting for XB_READY
//
//   Build option
//     XBUS_TIMEOUT_EN : when defined, a sync-mode strobe that never sees
//                       ready is ended after TIMEOUT_CYC cycles and BUS_ERR
//                       is set until reset. When undefined, sync strobes
//                       wait forever and BUS_ERR is tied low.
//
//   Ports
//     clk, rst          : core clock, asynchronous active-low reset
//     SYNC_MODE         : 1 = end strobe on XB_READY, 0 = fixed wait count
//     ASYNC_WAITCYCLE   : extra strobe cycles in fixed-wait mode
//     WB_ADRi/DATi/WEi  : request address, write data, write enable
//     WB_CYCi/STBi      : request qualifiers
//     WB_DATo, WB_ACKo  : read data, single-cycle acknowledge
//     XB_ADDR, XB_DO    : external address and write data
//     XB_DI             : external read data
//     XB_OE             : write data driver enable
//     XB_CS_n/RD_n/WR_n : active-low chip select and strobes
//     XB_READY          : asynchronous device ready
//     BUS_ERR           : sticky timeout flag
//
//   Handshake: a request is taken when WB_CYCi & WB_STBi are high at a clk
//   edge while the bridge is idle; address, WE and write data are captured
//   at that edge. WB_ACKo is high for exactly one cycle per request and the
//   bridge always returns to idle for one cycle before taking another.
//   Dropping WB_CYCi after acceptance does not cancel the external access.
module xbus_bridge #(
  parameter int SETUP_CYC   = 1,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SYNC_MODE,
  input  logic [6:0]  ASYNC_WAITCYCLE,
  input  logic [10:0] WB_ADRi,
  input  logic [7:0]  WB_DATi,
  output logic [7:0]  WB_DATo,
  input  logic        WB_WEi,
  input  logic        WB_CYCi,
  input  logic        WB_STBi,
  output logic        WB_ACKo,
  output logic [10:0] XB_ADDR,
  output logic [7:0]  XB_DO,
  input  logic [7:0]  XB_DI,
  output logic        XB_OE,
  output logic        XB_CS_n,
  output logic        XB_RD_n,
  output logic        XB_WR_n,
  input  logic        XB_READY,
  output logic        BUS_ERR
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  // One counter serves setup, strobe and hold; it must reach both the
  // largest wait count (127) and TIMEOUT_CYC-1.
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [10:0] ADDR_LIMIT = 11'h600;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    wait_q, wait_d;
  logic          sync_q, sync_d;
  logic          we_q, we_d;
  logic [10:0]   addr_q, addr_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [7:0]    dato_q, dato_d;
  logic          err_q, err_d;
  logic          rdy_meta, rdy_sync;
  logic          strobe_done, timeout, busy_d;
  logic          cs_n_q, rd_n_q, wr_n_q, oe_q, ack_q;

  always_comb begin
    strobe_done = sync_q ? rdy_sync : (cnt_q == CW'(wait_q));
`ifdef XBUS_TIMEOUT_EN
    // Ready arriving on the final allowed cycle still counts as success.
    timeout = sync_q && !rdy_sync && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    timeout = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    sync_d  = sync_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    dato_d  = dato_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (WB_CYCi && WB_STBi) begin
          addr_d = WB_ADRi;
          we_d   = WB_WEi;
          wdat_d = WB_DATi;
          cnt_d  = '0;
          if (WB_ADRi >= ADDR_LIMIT) begin
            // Unmapped space: answer at once, never touch the external bus.
            state_d = ST_ACK;
            dato_d  = 8'hFF;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          // Mode and wait count are frozen for the whole strobe here.
          state_d = ST_STROBE;
          cnt_d   = '0;
          wait_d  = ASYNC_WAITCYCLE;
          sync_d  = SYNC_MODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STROBE: begin
        if (strobe_done || timeout) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (timeout) begin
            err_d = 1'b1;
            if (!we_q) dato_d = 8'hFF;
          end else if (!we_q) begin
            dato_d = XB_DI;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
  end

  // Bus controls are registered from the next state so they are glitch-free,
  // and their async reset releases the strobes the moment rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      sync_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      dato_q   <= '0;
      err_q    <= 1'b0;
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      sync_q   <= sync_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      dato_q   <= dato_d;
      err_q    <= err_d;
      rdy_meta <= XB_READY;
      rdy_sync <= rdy_meta;
      cs_n_q   <= !busy_d;
      rd_n_q   <= !((state_d == ST_STROBE) && !we_d);
      wr_n_q   <= !((state_d == ST_STROBE) && we_d);
      oe_q     <= busy_d && we_d;
      ack_q    <= (state_d == ST_ACK);
    end
  end

  assign WB_DATo = dato_q;
  assign WB_ACKo = ack_q;
  assign XB_ADDR = addr_q;
  assign XB_DO   = wdat_q;
  assign XB_OE   = oe_q;
  assign XB_CS_n = cs_n_q;
  assign XB_RD_n = rd_n_q;
  assign XB_WR_n = wr_n_q;
`ifdef XBUS_TIMEOUT_EN
  assign BUS_ERR = err_q;
`else
  assign BUS_ERR = 1'b0;
`endif

endmodule
